gray_counter: RTL
=================

// Module: gray_counter
// PURPOSE
//  - Registered up/down counter with a Gray-coded output. It is the encode-side
//    counterpart of gray_to_binary.
//  - Generates Gray pointers/sequences that change one bit per step. Suitable
//    as the source side of a CDC pointer, or as a stimulus for gray_to_binary.
//  - Keeps a binary count internally and registers both the binary and the
//    Gray views, so they always describe the same value.
// PARAMETERS
//  - data_width   default 4    counter width in bits; legal range 2..32
// PORTS
//  - clk        in   1           rising-edge clock; single clock domain
//  - rst_n      in   1           asynchronous reset, active low
//  - clr        in   1           synchronous clear to zero
//  - load       in   1           synchronous load of load_val
//  - load_val   in   data_width  binary value to load
//  - en         in   1           count enable; one step per cycle while high
//  - up_dn      in   1           1 = count up, 0 = count down; sampled with en
//  - bin_out    out  data_width  registered binary count
//  - d_out      out  data_width  registered Gray code of bin_out
//  - wrap       out  1           registered one-cycle pulse on count wrap-around
// BEHAVIOUR
//  - Reset:
//    - One clock, clk. Reset rst_n is asynchronous, active low.
//    - While rst_n is low: bin_out = 0, d_out = 0, wrap = 0. Release is
//      synchronous to clk externally.
//  - Priority per clk edge: clr > load > en > hold.
//  - clr:
//    - bin_out <= 0, d_out <= 0, wrap <= 0.
//    - en and load are ignored that cycle.
//  - load:
//    - bin_out <= load_val, d_out <= load_val ^ (load_val >> 1), wrap <= 0.
//    - May change several d_out bits. Single-bit-change guarantee is void on
//      that cycle.
//  - en, up_dn = 1: bin_next = bin_out + 1, modulo 2**data_width.
//  - en, up_dn = 0: bin_next = bin_out - 1, modulo 2**data_width.
//  - Idle (no clr, load or en): all registers hold; wrap <= 0.
//  - Gray update:
//    - d_out is registered from bin_next in the same edge as bin_out.
//    - Invariant every cycle: d_out == bin_out ^ (bin_out >> 1).
//    - Latency from en to updated outputs: 1 clk.
//  - Step property: on every en-only step, exactly one bit of d_out toggles,
//    including at wrap-around.
//  - wrap:
//    - Pulses high for 1 cycle after an en step from all-ones to 0 (up), or
//      from 0 to all-ones (down).
//    - Never pulses on load or clr, even when the loaded value sits at a
//      boundary.
//  - Continuous en wraps indefinitely: period is 2**data_width cycles, with
//    one wrap pulse per period.
//  - A direction change takes effect on the same edge it is sampled. Example:
//    bin_out = 0, up_dn toggles to 0 with en high -> next bin_out = all-ones,
//    wrap = 1.
//  - Reset asserted mid-count forces all outputs to 0 immediately, without
//    waiting for clk.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Package gray_pkg:
//    - function bin2gray(bin) = bin ^ (bin >> 1)
//    - function gray2bin (prefix XOR from MSB), shared with gray_to_binary
//    - localparam GRAY_MAX_WIDTH = 32
//  - Sub-module binary_to_gray (parameter data_width):
//    - Purely combinational; instantiated once on bin_next.
//    - Mirror of gray_to_binary; reusable by other blocks.
//  - Top holds the bin_out, d_out and wrap registers plus next-state mux and
//    wrap detect.
// TESTING
//  - Reset: hold rst_n = 0 with en = 1 for 3 clk -> bin_out = 0, d_out = 0000,
//    wrap = 0 throughout. Release -> first step gives d_out = 0001.
//  - Up count, data_width = 4: en = 1, up_dn = 1 for 16 clk.
//    - d_out = 0001, 0011, 0010, 0110, ..., 1000, 0000.
//    - Exactly one bit toggles per step; wrap = 1 only on the cycle d_out
//      returns to 0000.
//  - Down wrap: load 0000, then en = 1, up_dn = 0.
//    - Outputs: bin_out = 1111, d_out = 1000, wrap = 1. Next step:
//      bin_out = 1110, d_out = 1001, wrap = 0.
//  - Priority: assert clr = 1, load = 1 (load_val = 1011) and en = 1 together
//    -> outputs 0000 / 0000.
//    - Then load = 1, en = 1 -> bin_out = 1011, d_out = 1110, wrap = 0.
//  - Round trip: feed d_out into a gray_to_binary instance while counting
//    randomly (up/down, 1000 cycles) -> its output equals bin_out every cycle.
//  - Async reset mid-count: drop rst_n between clk edges at bin_out = 0101
//    -> outputs 0 before the next edge; wrap stays 0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the encode (gray_counter) and decode
// (gray_to_binary) sides of a pointer path.
package gray_pkg;

  // Widest counter/pointer any Gray block in this library is built for.
  localparam int GRAY_MAX_WIDTH = 32;

  // Binary to reflected Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: running XOR starting from the MSB.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
    input logic [GRAY_MAX_WIDTH-1:0] gray
  );
    logic [GRAY_MAX_WIDTH-1:0] bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray encoder; mirror image of gray_to_binary.
module binary_to_gray #(
  parameter int data_width = 4
) (
  input  logic [data_width-1:0] bin,
  output logic [data_width-1:0] gray
);

  // The MSB passes straight through; every lower bit XORs with its upper neighbour.
  assign gray[data_width-1] = bin[data_width-1];

  generate
    for (genvar gi = 0; gi < data_width - 1; gi++) begin : g_bit
      assign gray[gi] = bin[gi] ^ bin[gi+1];
    end
  endgenerate

endmodule

// File: rtl/gray_counter.sv
// Up/down counter that registers both its binary count and the Gray code of
// that count on the same edge, so the two views never disagree. Also flags a
// one-cycle wrap pulse when a counting step crosses the all-ones/zero boundary.
module gray_counter
  import gray_pkg::*;
#(
  parameter int data_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [data_width-1:0] load_val,
  input  logic                  en,
  input  logic                  up_dn,
  output logic [data_width-1:0] bin_out,
  output logic [data_width-1:0] d_out,
  output logic                  wrap
);

  localparam logic [data_width-1:0] ONE_VAL = data_width'(1);

  logic [data_width-1:0] bin_reg;
  logic [data_width-1:0] bin_next;
  logic [data_width-1:0] gray_reg;
  logic [data_width-1:0] gray_next;
  logic                  wrap_reg;
  logic                  wrap_next;

  // Next-state mux (clr > load > en > hold) and wrap detection on counting steps only.
  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    if (clr) begin
      bin_next = '0;
    end else if (load) begin
      bin_next = load_val;
    end else if (en) begin
      if (up_dn) begin
        bin_next  = bin_reg + ONE_VAL;
        wrap_next = &bin_reg;
      end else begin
        bin_next  = bin_reg - ONE_VAL;
        wrap_next = ~|bin_reg;
      end
    end
  end

  // Gray is computed from bin_next, not bin_reg, so both registers load the same value.
  binary_to_gray #(
    .data_width(data_width)
  ) u_bin2gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Output registers; reset forces everything to zero without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bin_out = bin_reg;
  assign d_out   = gray_reg;
  assign wrap    = wrap_reg;

endmodule
